// File: rtl/fpga_link_tx_fifo.sv
// fpga_link_tx_fifo
//   Buffered FPGA-to-FPGA serial transmitter. Words pushed by local logic wait in a
//   small FIFO; each word is sent after a req/ack handshake with the partner FPGA,
//   one bit per clock with a frame strobe and an optional even-parity bit.
//
//   state  | meaning
//   IDLE   | nothing in flight, waiting for a buffered word and a released ack
//   REQ    | req_out high, waiting for synchronised ack (bounded by ACK_TIMEOUT)
//   SHIFT  | serialising the popped word (plus parity) on data_out/frame_out
//   FINISH | req_out dropped, waiting for the partner to release ack
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   wr_en, wr_data        producer push interface
//   fifo_full, fifo_empty registered FIFO occupancy flags
//   req_out, ack_in       handshake with partner (ack_in is asynchronous)
//   data_out, frame_out   serial bit and its valid strobe
//   busy, done            FSM active; 1-cycle pulse per completed word
//   timeout_err           1-cycle pulse when the partner never acknowledged
module fpga_link_tx_fifo #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int MSB_FIRST   = 0,
    parameter int PARITY_EN   = 1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              req_out,
    input  logic              ack_in,
    output logic              data_out,
    output logic              frame_out,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int N  = DATA_W + PARITY_EN;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(N + 1);
    localparam int WW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, SHIFT, FINISH} state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_next;
    logic              push, pop;
    logic [DATA_W-1:0] head;

    logic              ack_m, ack_s;
    state_t            state;
    logic [WW-1:0]     wait_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [N-1:0]      frame, shreg;

    // Pop only happens on the REQ->SHIFT transition; a write into a full FIFO
    // is still taken in that same cycle because a slot frees up.
    assign pop  = (state == REQ) && ack_s;
    assign push = wr_en && (!fifo_full || pop);
    assign head = mem[rd_ptr];

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    // Frame laid out in transmission order: bit 0 goes out first.
    always_comb begin
        frame = '0;
        for (int i = 0; i < DATA_W; i++) begin
            frame[i] = (MSB_FIRST != 0) ? head[DATA_W-1-i] : head[i];
        end
        if (PARITY_EN != 0) begin
            frame[N-1] = ^head;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_next;
            fifo_full  <= (count_next == CW'(FIFO_DEPTH));
            fifo_empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack_in;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            req_out     <= 1'b0;
            data_out    <= 1'b0;
            frame_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Wait for the partner to release ack before asking again.
                    if (!fifo_empty && !ack_s) begin
                        state    <= REQ;
                        req_out  <= 1'b1;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        state     <= SHIFT;
                        shreg     <= frame >> 1;
                        data_out  <= frame[0];
                        frame_out <= 1'b1;
                        bit_cnt   <= '0;
                    end else if (wait_cnt == WW'(ACK_TIMEOUT - 1)) begin
                        // Head word stays in the FIFO and is retried.
                        state       <= IDLE;
                        req_out     <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                SHIFT: begin
                    // bit_cnt is the index of the bit currently on data_out.
                    if (bit_cnt == BW'(N - 1)) begin
                        state     <= FINISH;
                        frame_out <= 1'b0;
                        data_out  <= 1'b0;
                        req_out   <= 1'b0;
                    end else begin
                        bit_cnt  <= bit_cnt + BW'(1);
                        data_out <= shreg[0];
                        shreg    <= shreg >> 1;
                    end
                end
                FINISH: begin
                    if (!ack_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_link_tx_fifo.sv
module tb_fpga_link_tx_fifo;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // sel picks which DUT the shared tasks drive and observe:
    // 0 = LSB-first instance, 1 = MSB-first instance.
    logic       sel = 1'b0;
    logic       wr_drv = 1'b0;
    logic       ack_drv = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic a_wr, a_ack, a_full, a_empty, a_req, a_data, a_frame, a_busy, a_done, a_to;
    logic b_wr, b_ack, b_full, b_empty, b_req, b_data, b_frame, b_busy, b_done, b_to;
    logic full_m, empty_m, req_m, data_m, frame_m, busy_m, done_m, to_m;

    assign a_wr  = wr_drv && !sel;
    assign a_ack = ack_drv && !sel;
    assign b_wr  = wr_drv && sel;
    assign b_ack = ack_drv && sel;

    assign full_m  = sel ? b_full  : a_full;
    assign empty_m = sel ? b_empty : a_empty;
    assign req_m   = sel ? b_req   : a_req;
    assign data_m  = sel ? b_data  : a_data;
    assign frame_m = sel ? b_frame : a_frame;
    assign busy_m  = sel ? b_busy  : a_busy;
    assign done_m  = sel ? b_done  : a_done;
    assign to_m    = sel ? b_to    : a_to;

    fpga_link_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0), .PARITY_EN(1), .ACK_TIMEOUT(10)) dut_a (
        .clk(clk), .reset(reset), .wr_en(a_wr), .wr_data(wdata),
        .fifo_full(a_full), .fifo_empty(a_empty), .req_out(a_req), .ack_in(a_ack),
        .data_out(a_data), .frame_out(a_frame), .busy(a_busy), .done(a_done), .timeout_err(a_to)
    );

    fpga_link_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1), .PARITY_EN(1), .ACK_TIMEOUT(10)) dut_b (
        .clk(clk), .reset(reset), .wr_en(b_wr), .wr_data(wdata),
        .fifo_full(b_full), .fifo_empty(b_empty), .req_out(b_req), .ack_in(b_ack),
        .data_out(b_data), .frame_out(b_frame), .busy(b_busy), .done(b_done), .timeout_err(b_to)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] model_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial sequence, index = transmit order; parity makes the 1s count even.
    function automatic logic [8:0] exp_frame(input logic [7:0] w, input bit msb);
        logic [8:0] f;
        for (int i = 0; i < 8; i++) f[i] = msb ? w[7-i] : w[i];
        f[8] = ($countones(w) % 2) == 1;
        return f;
    endfunction

    task automatic push_one(input logic [7:0] w);
        wdata  = w;
        wr_drv = 1'b1;
        if (!sel && model_q.size() < 4) model_q.push_back(w);
        @(negedge clk);
        wr_drv = 1'b0;
    endtask

    task automatic push_words(input int n);
        for (int k = 0; k < n; k++) push_one(8'($urandom));
    endtask

    // Align to a fresh REQ entry so ack timing is measured from its start.
    task automatic wait_req_rise();
        int c = 0;
        while (req_m && c < 60) begin @(negedge clk); c++; end
        while (!req_m && c < 60) begin @(negedge clk); c++; end
        chk("req_rise_in_time", 32'(c < 60), 1);
    endtask

    // Called at the negedge where ack was raised.
    task automatic finish_word(output logic [8:0] bits, output logic full_at_frame);
        int lat = 0;
        int nb = 0;
        int c = 0;
        while (!frame_m && lat < 20) begin @(negedge clk); lat++; end
        wr_drv = 1'b0;
        full_at_frame = full_m;
        chk("ack_to_first_bit", lat, 3);
        bits = '0;
        while (frame_m && nb < 20) begin
            if (nb < 9) bits[nb] = data_m;
            nb++;
            @(negedge clk);
        end
        chk("frame_len", nb, 9);
        chk("data_low_after_frame", data_m, 0);
        chk("req_low_in_finish", req_m, 0);
        ack_drv = 1'b0;
        while (!done_m && c < 20) begin @(negedge clk); c++; end
        chk("done_pulse", done_m, 1);
        chk("busy_at_done", busy_m, 0);
    endtask

    task automatic serve(input int d, output logic [8:0] bits);
        logic f;
        wait_req_rise();
        repeat (d) @(negedge clk);
        ack_drv = 1'b1;
        finish_word(bits, f);
    endtask

    task automatic check_word(input logic [8:0] bits, input string tag);
        logic [7:0] w;
        if (model_q.size() == 0) begin
            chk({tag, "_unexpected_word"}, bits, 32'hFFFF_FFFF);
        end else begin
            w = model_q.pop_front();
            chk(tag, bits, exp_frame(w, 1'b0));
        end
    endtask

    task automatic do_timeout();
        int c = 0;
        wait_req_rise();
        while (req_m && c < 40) begin @(negedge clk); c++; end
        chk("req_high_cycles", c, 10);
        chk("timeout_pulse", to_m, 1);
        @(negedge clk);
        chk("timeout_one_cycle", to_m, 0);
    endtask

    task automatic drain(input string tag);
        logic [8:0] bits;
        while (model_q.size() > 0) begin
            serve($urandom_range(0, 6), bits);
            check_word(bits, tag);
        end
        chk({tag, "_empty_after"}, empty_m, 1);
    endtask

    initial begin
        logic [8:0] bits;
        logic       f;
        logic [7:0] neww;
        int         c;
        int         cnt_done;
        int         cnt_req;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {a_req, a_data, a_frame, a_busy, a_done, a_to}, 0);
        chk("reset_flags", {a_full, a_empty}, 2'b01);
        reset = 1'b0;
        @(negedge clk);

        // A5, LSB first, ack 3 cycles after req
        push_one(8'hA5);
        serve(3, bits);
        chk("a5_bits", bits, 9'b0_1010_0101);
        check_word(bits, "a5_model");
        chk("a5_empty", a_empty, 1);

        // 01, MSB first
        sel = 1'b1;
        @(negedge clk);
        push_one(8'h01);
        serve(2, bits);
        chk("msb_01_bits", bits, 9'b1_1000_0000);
        chk("msb_empty", b_empty, 1);
        sel = 1'b0;
        @(negedge clk);

        // Five pushes into depth 4 with partner silent
        push_words(5);
        chk("five_push_full", a_full, 1);
        chk("five_push_not_empty", a_empty, 0);
        drain("overflow_order");
        cnt_req = 0;
        for (int k = 0; k < 15; k++) begin @(negedge clk); if (a_req) cnt_req++; end
        chk("no_fifth_word", cnt_req, 0);

        // Timeout then retry of the same head word
        push_one(8'($urandom));
        do_timeout();
        serve(1, bits);
        check_word(bits, "retry_word");

        // Write into full FIFO in the pop cycle
        push_words(4);
        chk("pop_push_full_before", a_full, 1);
        wait_req_rise();
        neww    = 8'h3C;
        wdata   = neww;
        wr_drv  = 1'b1;
        ack_drv = 1'b1;
        finish_word(bits, f);
        chk("pop_push_full_at_pop", f, 1);
        check_word(bits, "pop_push_head");
        model_q.push_back(neww);
        chk("pop_push_full_after", a_full, 1);
        drain("pop_push_order");

        // Randomized bursts
        for (int r = 0; r < 8; r++) begin
            push_words($urandom_range(1, 6));
            chk("rand_full", a_full, 32'(model_q.size() == 4));
            chk("rand_empty", a_empty, 0);
            if ($urandom_range(0, 3) == 0) do_timeout();
            drain("rand_word");
        end

        // Reset during bit 4 with three words still queued
        push_words(4);
        wait_req_rise();
        ack_drv = 1'b1;
        c = 0;
        while (!a_frame && c < 20) begin @(negedge clk); c++; end
        chk("reset_test_frame_seen", a_frame, 1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midword_reset_outputs", {a_req, a_data, a_frame, a_busy, a_done, a_to}, 0);
        chk("midword_reset_flags", {a_full, a_empty}, 2'b01);
        ack_drv = 1'b0;
        model_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cnt_done = 0;
        cnt_req  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (a_done) cnt_done++;
            if (a_req)  cnt_req++;
        end
        chk("no_done_after_reset", cnt_done, 0);
        chk("no_req_after_reset", cnt_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
